// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, and one
// key_code/key_pulse event per accepted keystroke.
`timescale 1ns/1ps

module keypad_scanner #(
  parameter int unsigned SCAN_TICKS      = 27000,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_pulse,
  output logic       key_held
);

  localparam int unsigned DW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    sync1, rs;
  logic [DW-1:0] dwell_cnt, dwell_nx;
  logic [BW-1:0] db_cnt, db_nx;
  logic [1:0]    col_idx, col_nx;
  logic [1:0]    row_idx, row_nx;
  logic [3:0]    code_nx;
  logic          pulse_nx;
  logic          held_nx;
  logic [3:0]    row_low;
  logic [1:0]    first_low;
  logic          tracked_high;

  // Row/column position to key code
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer; idles high like the pulled-up rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'b1111;
      rs    <= 4'b1111;
    end else begin
      sync1 <= row_n;
      rs    <= sync1;
    end
  end

  // Lowest-index low row wins when several rows share the active column
  always_comb begin
    row_low   = ~rs;
    first_low = 2'd0;
    if (row_low[0])      first_low = 2'd0;
    else if (row_low[1]) first_low = 2'd1;
    else if (row_low[2]) first_low = 2'd2;
    else if (row_low[3]) first_low = 2'd3;
  end

  assign tracked_high = rs[row_idx];

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    dwell_nx = dwell_cnt;
    db_nx    = db_cnt;
    col_nx   = col_idx;
    row_nx   = row_idx;
    code_nx  = key_code;
    pulse_nx = 1'b0;
    held_nx  = 1'b0;

    case (state)
      ST_SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nx = '0;
          if (|row_low) begin
            row_nx   = first_low;
            db_nx    = '0;
            state_nx = ST_DEBOUNCE;
          end else begin
            col_nx = col_idx + 2'd1;
          end
        end else begin
          dwell_nx = dwell_cnt + DW'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (tracked_high) begin
          dwell_nx = '0;
          state_nx = ST_SCAN;
        end else if (db_cnt == DB_LAST) begin
          code_nx  = map_key(row_idx, col_idx);
          pulse_nx = 1'b1;
          held_nx  = 1'b1;
          state_nx = ST_HELD;
        end else begin
          db_nx = db_cnt + BW'(1);
        end
      end

      ST_HELD: begin
        held_nx = 1'b1;
        if (tracked_high) begin
          db_nx    = '0;
          state_nx = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        held_nx = 1'b1;
        if (!tracked_high) begin
          state_nx = ST_HELD;
        end else if (db_cnt == DB_LAST) begin
          held_nx  = 1'b0;
          col_nx   = col_idx + 2'd1;
          dwell_nx = '0;
          state_nx = ST_SCAN;
        end else begin
          db_nx = db_cnt + BW'(1);
        end
      end

      default: state_nx = ST_SCAN;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SCAN;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      col_n     <= 4'b1110;
      key_code  <= 4'd0;
      key_pulse <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      dwell_cnt <= dwell_nx;
      db_cnt    <= db_nx;
      col_idx   <= col_nx;
      row_idx   <= row_nx;
      col_n     <= ~(4'b0001 << col_nx);
      key_code  <= code_nx;
      key_pulse <= pulse_nx;
      key_held  <= held_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad matrix.
`timescale 1ns/1ps

module tb_keypad_scanner;

  localparam int unsigned SCAN_TICKS      = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_pulse;
  logic        key_held;

  logic [15:0] keymat;          // bit r*4+c set = key (r,c) pressed
  int          vectors = 0;
  int          errors  = 0;
  int          pulse_cnt = 0;
  logic [3:0]  last_code = 4'd0;
  logic [3:0]  codes[$];
  logic        prev_pulse = 1'b0;
  bit          dbl_pulse = 1'b0;
  bit          held_bad  = 1'b0;

  keypad_scanner #(
    .SCAN_TICKS     (SCAN_TICKS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_pulse(key_pulse),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      row_n[r] = ~|(keymat[r*4 +: 4] & ~col_n);
  end

  // Pulse monitor sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (key_pulse === 1'b1) begin
      pulse_cnt++;
      last_code = key_code;
      codes.push_back(key_code);
      if (key_held !== 1'b1) held_bad = 1'b1;
      if (prev_pulse === 1'b1) dbl_pulse = 1'b1;
    end
    prev_pulse = key_pulse;
  end

  task automatic press(input int r, input int c);
    keymat[r*4 + c] = 1'b1;
  endtask

  task automatic release_all();
    keymat = '0;
  endtask

  task automatic wait_col(input int c, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << c[1:0]);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (col_n === want) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_pulse(input int start, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pulse_cnt > start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Negedges from release until key_held is seen low (bounded)
  task automatic measure_fall(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (key_held === 1'b0) return;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    keymat = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col_n: got %b expected 1110", col_n); end
    vectors++;
    if (key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code: got %0d expected 0", key_code); end
    vectors++;
    if (key_pulse !== 1'b0) begin errors++; $display("FAIL reset_key_pulse: got %b expected 0", key_pulse); end
    vectors++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b expected 0", key_held); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (col_n !== 4'b1110) begin errors++; $display("FAIL scan_dwell_col0: got %b expected 1110", col_n); end
    @(negedge clk);
    vectors++;
    if (col_n !== 4'b1101) begin errors++; $display("FAIL scan_advance_col1: got %b expected 1101", col_n); end
  endtask

  task automatic test_single_key();
    int start, n;
    bit ok, hb;
    start = pulse_cnt;
    press(2, 1);
    wait_pulse(start, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL single_pulse_seen: got none expected 1"); end
    vectors++;
    if (last_code !== 4'd8) begin errors++; $display("FAIL single_code: got %0d expected 8", last_code); end
    hb = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (key_held !== 1'b1) hb = 1'b1;
    end
    vectors++;
    if (hb) begin errors++; $display("FAIL single_held_level: got low expected high while pressed"); end
    release_all();
    measure_fall(n);
    vectors++;
    if (n !== 11) begin errors++; $display("FAIL single_release_latency: got %0d expected 11", n); end
    vectors++;
    if (col_n !== 4'b1011) begin errors++; $display("FAIL single_next_col: got %b expected 1011", col_n); end
    repeat (5) @(negedge clk);
    vectors++;
    if (pulse_cnt - start !== 1) begin errors++; $display("FAIL single_pulse_count: got %0d expected 1", pulse_cnt - start); end
  endtask

  task automatic test_sequence();
    int start, qstart;
    int rr[3] = '{3, 0, 2};
    int cc[3] = '{1, 3, 3};
    int ec[3] = '{0, 10, 12};
    start  = pulse_cnt;
    qstart = codes.size();
    for (int k = 0; k < 3; k++) begin
      press(rr[k], cc[k]);
      repeat (40) @(negedge clk);
      release_all();
      repeat (40) @(negedge clk);
    end
    vectors++;
    if (pulse_cnt - start !== 3) begin errors++; $display("FAIL seq_pulse_count: got %0d expected 3", pulse_cnt - start); end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (codes.size() < qstart + k + 1) begin
        errors++;
        $display("FAIL seq_code%0d: got none expected %0d", k, ec[k]);
      end else if (codes[qstart + k] !== 4'(ec[k])) begin
        errors++;
        $display("FAIL seq_code%0d: got %0d expected %0d", k, codes[qstart + k], ec[k]);
      end
    end
  endtask

  task automatic test_press_bounce();
    int start;
    bit ok3, ok0, hb;
    start = pulse_cnt;
    wait_col(3, ok3);
    wait_col(0, ok0);
    vectors++;
    if (!(ok3 && ok0)) begin errors++; $display("FAIL bounce_col_sync: got timeout expected column 0 reached"); end
    press(1, 0);
    hb = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 5) release_all();
      if (key_held !== 1'b0) hb = 1'b1;
    end
    vectors++;
    if (col_n !== 4'b1110) begin errors++; $display("FAIL bounce_rescan_col0: got %b expected 1110", col_n); end
    @(negedge clk);
    vectors++;
    if (col_n !== 4'b1101) begin errors++; $display("FAIL bounce_rescan_col1: got %b expected 1101", col_n); end
    repeat (20) begin
      @(negedge clk);
      if (key_held !== 1'b0) hb = 1'b1;
    end
    vectors++;
    if (hb) begin errors++; $display("FAIL bounce_held: got high expected low"); end
    vectors++;
    if (pulse_cnt - start !== 0) begin errors++; $display("FAIL bounce_pulse_count: got %0d expected 0", pulse_cnt - start); end
  endtask

  task automatic test_release_bounce();
    int start, n;
    bit ok, hb;
    start = pulse_cnt;
    press(1, 1);
    wait_pulse(start, ok);
    vectors++;
    if (!ok || last_code !== 4'd5) begin errors++; $display("FAIL rbounce_code: got %0d expected 5", last_code); end
    hb = 1'b0;
    repeat (5) begin @(negedge clk); if (key_held !== 1'b1) hb = 1'b1; end
    release_all();
    repeat (3) begin @(negedge clk); if (key_held !== 1'b1) hb = 1'b1; end
    press(1, 1);
    repeat (10) begin @(negedge clk); if (key_held !== 1'b1) hb = 1'b1; end
    vectors++;
    if (hb) begin errors++; $display("FAIL rbounce_held_through: got low expected high"); end
    release_all();
    measure_fall(n);
    vectors++;
    if (n !== 11) begin errors++; $display("FAIL rbounce_release_latency: got %0d expected 11", n); end
    vectors++;
    if (col_n !== 4'b1011) begin errors++; $display("FAIL rbounce_next_col: got %b expected 1011", col_n); end
    repeat (5) @(negedge clk);
    vectors++;
    if (pulse_cnt - start !== 1) begin errors++; $display("FAIL rbounce_pulse_count: got %0d expected 1", pulse_cnt - start); end
  endtask

  task automatic test_two_keys();
    int start, n;
    bit ok;
    start = pulse_cnt;
    press(1, 0);
    press(2, 0);
    wait_pulse(start, ok);
    vectors++;
    if (!ok || last_code !== 4'd4) begin errors++; $display("FAIL two_keys_code: got %0d expected 4", last_code); end
    repeat (10) @(negedge clk);
    release_all();
    measure_fall(n);
    repeat (5) @(negedge clk);
    vectors++;
    if (pulse_cnt - start !== 1) begin errors++; $display("FAIL two_keys_pulse_count: got %0d expected 1", pulse_cnt - start); end
  endtask

  task automatic test_reset_held();
    int start;
    bit ok;
    start = pulse_cnt;
    press(2, 2);
    wait_pulse(start, ok);
    vectors++;
    if (!ok || last_code !== 4'd9) begin errors++; $display("FAIL rst_held_code: got %0d expected 9", last_code); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (key_held !== 1'b0) begin errors++; $display("FAIL rst_held_key_held: got %b expected 0", key_held); end
    vectors++;
    if (key_pulse !== 1'b0) begin errors++; $display("FAIL rst_held_key_pulse: got %b expected 0", key_pulse); end
    vectors++;
    if (key_code !== 4'd0) begin errors++; $display("FAIL rst_held_key_code: got %0d expected 0", key_code); end
    vectors++;
    if (col_n !== 4'b1110) begin errors++; $display("FAIL rst_held_col_n: got %b expected 1110", col_n); end
    @(negedge clk);
    rst = 1'b0;
    start = pulse_cnt;
    release_all();
    repeat (60) @(negedge clk);
    vectors++;
    if (pulse_cnt - start !== 0) begin errors++; $display("FAIL rst_held_no_pulse: got %0d expected 0", pulse_cnt - start); end
  endtask

  task automatic test_pulse_shape();
    vectors++;
    if (dbl_pulse) begin errors++; $display("FAIL pulse_consecutive: got 2-cycle pulse expected 1-cycle"); end
    vectors++;
    if (held_bad) begin errors++; $display("FAIL pulse_held_align: got key_held low at pulse expected high"); end
  endtask

  initial begin
    rst    = 1'b1;
    keymat = '0;
    test_reset();
    test_single_key();
    test_sequence();
    test_press_bounce();
    test_release_bounce();
    test_two_keys();
    test_reset_held();
    test_pulse_shape();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
